// File: rtl/ad_pll.sv
// ad_pll: all-digital PLL that locks a phase-accumulator DCO to an external reference clock.
// Counter-based phase/frequency detector feeding a saturating PI loop filter.
module ad_pll #(
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned FCW_NOM  = 1311,
    parameter int          KP       = 2,
    parameter int unsigned KI_SHIFT = 2,
    parameter int          INT_LIM  = 2047
) (
    input  logic              fpga_clk_i,
    input  logic              reset_i,
    input  logic              ref_clk_i,
    input  logic              enable_i,
    output logic              gen_clk_o,
    output logic signed [7:0] error_o,
    output logic signed [8:0] dco_cc_o
);
    localparam int unsigned ERR_W = 8;
    localparam int unsigned CC_W  = 9;
    localparam int unsigned INT_W = 12;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SUM_W = 16;

    localparam logic [CNT_W-1:0]        CNT_MAX = '1;
    localparam logic [CNT_W-1:0]        ERR_CAP = CNT_W'(127);
    localparam logic signed [SUM_W-1:0] INT_HI  = SUM_W'(INT_LIM);
    localparam logic signed [SUM_W-1:0] INT_LO  = -SUM_W'(INT_LIM);
    localparam logic signed [SUM_W-1:0] CC_HI   = SUM_W'(255);
    localparam logic signed [SUM_W-1:0] CC_LO   = -SUM_W'(255);

    typedef enum logic [1:0] {
        IDLE,
        REF_FIRST,
        GEN_FIRST
    } pd_state_e;

    logic                     ref_s1_q, ref_s2_q, ref_h_q, gen_h_q;
    logic [ACC_W-1:0]         acc_q, acc_d;
    pd_state_e                state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     upd_q;
    logic signed [ERR_W-1:0]  err_q;
    logic signed [INT_W-1:0]  integ_q, integ_d;
    logic signed [CC_W-1:0]   dco_cc_q, cc_d;

    logic                     ref_rise, gen_rise;
    logic [CNT_W-1:0]         cnt_cap;
    logic signed [ERR_W-1:0]  err_mag;
    logic signed [SUM_W-1:0]  int_sum, int_sat, cc_sum, cc_sat;

    assign ref_rise  = ref_s2_q & ~ref_h_q;
    assign gen_rise  = acc_q[ACC_W-1] & ~gen_h_q;
    assign cnt_cap   = (cnt_q > ERR_CAP) ? ERR_CAP : cnt_q;
    assign err_mag   = signed'(ERR_W'(cnt_cap));
    assign acc_d     = acc_q + ACC_W'(FCW_NOM) + ACC_W'(dco_cc_q);

    assign gen_clk_o = acc_q[ACC_W-1];
    assign error_o   = err_q;
    assign dco_cc_o  = dco_cc_q;

    // Reference synchronizer, gen edge history and free-running DCO accumulator.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            ref_s1_q <= 1'b0;
            ref_s2_q <= 1'b0;
            ref_h_q  <= 1'b0;
            gen_h_q  <= 1'b0;
            acc_q    <= '0;
        end else begin
            ref_s1_q <= ref_clk_i;
            ref_s2_q <= ref_s1_q;
            ref_h_q  <= ref_s2_q;
            gen_h_q  <= acc_q[ACC_W-1];
            acc_q    <= acc_d;
        end
    end

    // Phase detector: count cycles from the first edge to the other; timeout closes at the cap.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            upd_q   <= 1'b0;
        end else if (!enable_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ref_rise && gen_rise) begin
                        err_q <= '0;
                        upd_q <= 1'b1;
                    end else if (ref_rise) begin
                        state_q <= REF_FIRST;
                        cnt_q   <= CNT_W'(1);
                    end else if (gen_rise) begin
                        state_q <= GEN_FIRST;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                REF_FIRST: begin
                    if (gen_rise || cnt_q == CNT_MAX) begin
                        err_q   <= err_mag;
                        upd_q   <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                GEN_FIRST: begin
                    if (ref_rise || cnt_q == CNT_MAX) begin
                        err_q   <= -err_mag;
                        upd_q   <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // PI filter arithmetic, wide enough that neither sum can wrap before saturation.
    always_comb begin
        int_sum = SUM_W'(integ_q) + SUM_W'(err_q);
        if (int_sum > INT_HI) begin
            int_sat = INT_HI;
        end else if (int_sum < INT_LO) begin
            int_sat = INT_LO;
        end else begin
            int_sat = int_sum;
        end
        integ_d = INT_W'(int_sat);

        cc_sum = SUM_W'(err_q) * SUM_W'(KP) + (int_sat >>> KI_SHIFT);
        if (cc_sum > CC_HI) begin
            cc_sat = CC_HI;
        end else if (cc_sum < CC_LO) begin
            cc_sat = CC_LO;
        end else begin
            cc_sat = cc_sum;
        end
        cc_d = CC_W'(cc_sat);
    end

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            integ_q  <= '0;
            dco_cc_q <= '0;
        end else if (!enable_i) begin
            integ_q  <= '0;
            dco_cc_q <= '0;
        end else if (upd_q) begin
            integ_q  <= integ_d;
            dco_cc_q <= cc_d;
        end
    end

endmodule

// File: tb/tb_ad_pll.sv
// Directed self-checking bench for ad_pll: reset, open-loop DCO, phase detector edges,
// timeout saturation, lock, reset while locked and disable while locked.
module tb_ad_pll;
    logic              fpga_clk_i = 1'b0;
    logic              reset_i;
    logic              ref_clk_i;
    logic              enable_i;
    logic              gen_clk_o;
    logic signed [7:0] error_o;
    logic signed [8:0] dco_cc_o;

    logic ref_osc = 1'b0;
    logic ref_man;
    logic ref_run;
    logic mon_zero;
    int   nz_cnt = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    assign ref_clk_i = ref_run ? ref_osc : ref_man;

    always #2 fpga_clk_i = ~fpga_clk_i;
    always #99 ref_osc = ~ref_osc;

    always @(negedge fpga_clk_i) begin
        if (mon_zero && (error_o !== 8'sd0 || dco_cc_o !== 9'sd0)) nz_cnt++;
    end

    ad_pll dut (
        .fpga_clk_i (fpga_clk_i),
        .reset_i    (reset_i),
        .ref_clk_i  (ref_clk_i),
        .enable_i   (enable_i),
        .gen_clk_o  (gen_clk_o),
        .error_o    (error_o),
        .dco_cc_o   (dco_cc_o)
    );

    task automatic cycles(input int n);
        repeat (n) @(posedge fpga_clk_i);
        #1;
    endtask

    // Leaves time just after a posedge; the next posedge is the first running cycle.
    task automatic do_reset(input logic en);
        ref_run  = 1'b0;
        ref_man  = 1'b0;
        enable_i = en;
        reset_i  = 1'b1;
        cycles(2);
        reset_i  = 1'b0;
    endtask

    task automatic measure_periods(input int n, output int total, output int bad, output bit tmo);
        int   cnt;
        logic prev;
        total = 0;
        bad   = 0;
        tmo   = 1'b0;
        cnt   = 0;
        do begin
            prev = gen_clk_o;
            cycles(1);
            cnt++;
        end while (!(gen_clk_o && !prev) && cnt < 200);
        if (cnt >= 200) tmo = 1'b1;
        for (int p = 0; p < n && !tmo; p++) begin
            cnt = 0;
            do begin
                prev = gen_clk_o;
                cycles(1);
                cnt++;
            end while (!(gen_clk_o && !prev) && cnt < 200);
            if (cnt >= 200) tmo = 1'b1;
            total += cnt;
            if (cnt < 49 || cnt > 51) bad++;
        end
    endtask

    task automatic test_reset();
        ref_run  = 1'b0;
        ref_man  = 1'b0;
        enable_i = 1'b1;
        reset_i  = 1'b1;
        cycles(2);
        n_vec++;
        if (error_o !== 8'sd0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", error_o); end
        n_vec++;
        if (dco_cc_o !== 9'sd0) begin n_bad++; $display("FAIL reset_cc: got %0d want 0", dco_cc_o); end
        n_vec++;
        if (gen_clk_o !== 1'b0) begin n_bad++; $display("FAIL reset_gen: got %b want 0", gen_clk_o); end
    endtask

    task automatic test_open_loop();
        int total, bad, nz0;
        bit tmo;
        do_reset(1'b0);
        ref_run  = 1'b1;
        nz0      = nz_cnt;
        mon_zero = 1'b1;
        measure_periods(20, total, bad, tmo);
        mon_zero = 1'b0;
        n_vec++;
        if (tmo) begin n_bad++; $display("FAIL open_timeout: gen_clk_o edge not seen within 200 cycles"); end
        n_vec++;
        if (bad != 0) begin n_bad++; $display("FAIL open_period: %0d periods outside 49..51", bad); end
        n_vec++;
        if (total < 999 || total > 1001) begin
            n_bad++; $display("FAIL open_total: 20 periods took %0d cycles, want 999..1001", total);
        end
        n_vec++;
        if (nz_cnt != nz0) begin
            n_bad++; $display("FAIL open_zero: %0d samples with nonzero error_o/dco_cc_o, want 0", nz_cnt - nz0);
        end
    endtask

    task automatic test_ref_leads();
        do_reset(1'b1);
        cycles(13);
        ref_man = 1'b1;
        cycles(12);
        n_vec++;
        if (error_o !== 8'sd0) begin n_bad++; $display("FAIL refl_early: got %0d want 0", error_o); end
        cycles(1);
        n_vec++;
        if (error_o !== 8'sd10) begin n_bad++; $display("FAIL refl_err: got %0d want 10", error_o); end
        n_vec++;
        if (dco_cc_o !== 9'sd0) begin n_bad++; $display("FAIL refl_cc_early: got %0d want 0", dco_cc_o); end
        cycles(1);
        n_vec++;
        if (dco_cc_o !== 9'sd22) begin n_bad++; $display("FAIL refl_cc: got %0d want 22", dco_cc_o); end
        n_vec++;
        if (error_o !== 8'sd10) begin n_bad++; $display("FAIL refl_hold: got %0d want 10", error_o); end
    endtask

    task automatic test_gen_leads();
        do_reset(1'b1);
        cycles(33);
        ref_man = 1'b1;
        cycles(2);
        n_vec++;
        if (error_o !== 8'sd0) begin n_bad++; $display("FAIL genl_early: got %0d want 0", error_o); end
        cycles(1);
        n_vec++;
        if (error_o !== -8'sd10) begin n_bad++; $display("FAIL genl_err: got %0d want -10", error_o); end
        cycles(1);
        n_vec++;
        if (dco_cc_o !== -9'sd23) begin n_bad++; $display("FAIL genl_cc: got %0d want -23", dco_cc_o); end
    endtask

    task automatic test_timeout();
        int dev;
        do_reset(1'b1);
        cycles(280);
        n_vec++;
        if (error_o !== 8'sd0) begin n_bad++; $display("FAIL tmo_early: got %0d want 0", error_o); end
        cycles(1);
        n_vec++;
        if (error_o !== -8'sd127) begin n_bad++; $display("FAIL tmo_err: got %0d want -127", error_o); end
        cycles(1);
        n_vec++;
        if (dco_cc_o !== -9'sd255) begin n_bad++; $display("FAIL tmo_cc: got %0d want -255", dco_cc_o); end
        dev = 0;
        for (int i = 0; i < 8000; i++) begin
            cycles(1);
            if (dco_cc_o !== -9'sd255) dev++;
        end
        n_vec++;
        if (dev != 0) begin n_bad++; $display("FAIL tmo_sat: %0d cycles with dco_cc_o != -255, want 0", dev); end
        n_vec++;
        if (error_o !== -8'sd127) begin n_bad++; $display("FAIL tmo_last: got %0d want -127", error_o); end
    endtask

    task automatic check_lock(input string tag);
        int max_abs, sum_cc, e;
        cycles(10000);
        max_abs = 0;
        sum_cc  = 0;
        for (int i = 0; i < 2000; i++) begin
            cycles(1);
            e = int'(error_o);
            if (e < 0) e = -e;
            if (e > max_abs) max_abs = e;
            sum_cc += int'(dco_cc_o);
        end
        n_vec++;
        if (max_abs > 3) begin n_bad++; $display("FAIL %s_err: max |error_o| %0d, want <= 3", tag, max_abs); end
        n_vec++;
        if (sum_cc < 8 * 2000 || sum_cc > 18 * 2000) begin
            n_bad++; $display("FAIL %s_cc: mean dco_cc_o %0d/2000, want 8..18", tag, sum_cc);
        end
    endtask

    task automatic test_lock();
        do_reset(1'b0);
        ref_run = 1'b1;
        #200;
        enable_i = 1'b1;
        check_lock("lock");
    endtask

    task automatic test_reset_mid_lock();
        reset_i = 1'b1;
        #1;
        n_vec++;
        if (error_o !== 8'sd0) begin n_bad++; $display("FAIL midrst_err: got %0d want 0", error_o); end
        n_vec++;
        if (dco_cc_o !== 9'sd0) begin n_bad++; $display("FAIL midrst_cc: got %0d want 0", dco_cc_o); end
        n_vec++;
        if (gen_clk_o !== 1'b0) begin n_bad++; $display("FAIL midrst_gen: got %b want 0", gen_clk_o); end
        cycles(3);
        reset_i = 1'b0;
        check_lock("relock");
    endtask

    task automatic test_disable();
        int total, bad;
        bit tmo;
        enable_i = 1'b0;
        cycles(1);
        n_vec++;
        if (dco_cc_o !== 9'sd0) begin n_bad++; $display("FAIL dis_cc: got %0d want 0", dco_cc_o); end
        n_vec++;
        if (error_o !== 8'sd0) begin n_bad++; $display("FAIL dis_err: got %0d want 0", error_o); end
        measure_periods(10, total, bad, tmo);
        n_vec++;
        if (tmo || bad != 0) begin
            n_bad++; $display("FAIL dis_period: %0d periods outside 49..51 (edge timeout %0d)", bad, tmo);
        end
        n_vec++;
        if (total < 499 || total > 501) begin
            n_bad++; $display("FAIL dis_total: 10 periods took %0d cycles, want 499..501", total);
        end
    endtask

    initial begin
        mon_zero = 1'b0;
        ref_run  = 1'b0;
        ref_man  = 1'b0;
        enable_i = 1'b0;
        reset_i  = 1'b1;
        test_reset();
        test_open_loop();
        test_ref_leads();
        test_gen_leads();
        test_timeout();
        test_lock();
        test_reset_mid_lock();
        test_disable();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ad_pll.md
# ad_pll

All-digital phase-locked loop clocked from the single fast FPGA clock. It locks a generated clock (`gen_clk_o`) to an external reference clock (`ref_clk_i`). The loop has three parts: a counter-based phase/frequency detector, a proportional-integral loop filter, and a phase-accumulator DCO. The signed phase error is exported for a downstream signed-to-hex converter and seven-segment display interface, which are outside this block.

## Interface
Parameters:
- `ACC_W`, 16: DCO phase-accumulator width.
- `FCW_NOM`, 1311: nominal frequency control word (≈2^16/50, i.e. gen period ≈50 fpga cycles).
- `KP`, 2: proportional gain (integer multiplier).
- `KI_SHIFT`, 2: integrator right-shift.
- `INT_LIM`, 2047: integrator saturation magnitude.

Ports:
- `fpga_clk_i`  in  1: the one clock for all logic (250 MHz nominal).
- `reset_i`  in  1: reset, asynchronous, active-high.
- `ref_clk_i`  in  1: reference clock, asynchronous to `fpga_clk_i` (≈5 MHz, ≈49.5 fpga cycles per period).
- `enable_i`  in  1: loop enable.
- `gen_clk_o`  out  1: generated clock (accumulator MSB).
- `error_o`  out  8 signed: last measured phase error in fpga cycles. Positive means gen lags ref.
- `dco_cc_o`  out  9 signed: DCO control code.

## Operation
- Ref input path: 2-flop synchronizer plus one history flop. `ref_rise` is a one-cycle pulse on the synchronized 0→1 transition.
- Gen edge: `gen_rise` is a one-cycle pulse when the accumulator MSB goes 0→1.
- DCO:
  - Each cycle, `acc <= acc + FCW_NOM + sign_extend(dco_cc)`, wrapping modulo 2^ACC_W.
  - `gen_clk_o = acc[ACC_W-1]`.
- Phase detector FSM, states IDLE, REF_FIRST, GEN_FIRST, with 8-bit unsigned counter `cnt`:
  - IDLE: `ref_rise` and `gen_rise` together → emit error 0, stay IDLE. `ref_rise` only → REF_FIRST, cnt=1. `gen_rise` only → GEN_FIRST, cnt=1.
  - REF_FIRST: on `gen_rise`, emit +min(cnt,127) and go to IDLE. Otherwise cnt increments. A `ref_rise` received here is ignored.
  - GEN_FIRST: on `ref_rise`, emit −min(cnt,127) and go to IDLE. Otherwise cnt increments. A `gen_rise` received here is ignored.
  - Timeout: cnt reaching 255 without the closing edge emits ±127 (sign by state) and goes to IDLE.
  - "Emit" means register `error_o` and pulse internal `upd` for one cycle.
- Loop filter, evaluated on `upd`:
  - `integ <= sat(integ + error, ±INT_LIM)`, 12-bit signed.
  - `dco_cc_o <= sat(KP*error + (integ_new >>> KI_SHIFT), −255..+255)`.
  - Use ≥13-bit intermediate arithmetic. `>>>` is arithmetic and rounds toward −∞.
- `enable_i` low:
  - FSM forced to IDLE, cnt, integ, `error_o` and `dco_cc_o` held at 0.
  - DCO keeps running at FCW_NOM.
  - On re-enable, the loop starts from these zero values.

## Timing
- Reset values: `acc`=0, `gen_clk_o`=0, `error_o`=0, `dco_cc_o`=0, `integ`=0, FSM IDLE, cnt=0, synchronizer flops 0.
- Ref edge latency: 2–3 fpga cycles from the `ref_clk_i` rising edge to `ref_rise`. The error measures the synchronized edge, so the bias is constant and not compensated.
- Error update: `error_o` updates on the cycle after the closing edge pulse.
- Control update: `dco_cc_o` updates one cycle after `error_o`. The DCO uses the new code on the following cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The first measurement after release starts from IDLE.
- Locked behaviour with the nominal ref (49.5 cycles):
  - `dco_cc_o` settles near +13 (FCW≈1324).
  - `|error_o|` ≤ 3 within 200 ref periods.

## Test plan
- Reset then `enable_i`=0 → `error_o`=0 and `dco_cc_o`=0; `gen_clk_o` period 49–51 cycles (average 50.0 over 20 periods).
- Enabled. Force ref edge so `ref_rise` leads `gen_rise` by 10 cycles → `error_o`=+10, then `dco_cc_o`=sat(20 + integ>>>2) on the next cycle. Mirrored case (gen leads ref by 10) → `error_o`=−10.
- Hold `ref_clk_i` low while enabled → REF/GEN timeout → `error_o`=−127. `dco_cc_o` ramps to −255 and saturates there, with no wrap.
- Ref period 198 ns (49.5 cycles), enable at 200 ns → lock: `|error_o|` ≤ 3 and `dco_cc_o` in 8..18 after 40 µs.
- Assert `reset_i` mid-lock for 3 cycles → all outputs 0 asynchronously. After release the loop re-locks under the same criteria.
- Drop `enable_i` while locked → `dco_cc_o`=0 and `error_o`=0 next cycle; gen period returns to 50 cycles.
